// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   SEL_*  : op select codes understood by ALU1bit
//   state_t: sequencer state encoding
package alu_pkg;

   localparam logic [1:0] SEL_AND  = 2'b00;
   localparam logic [1:0] SEL_OR   = 2'b01;
   localparam logic [1:0] SEL_XOR  = 2'b10;
   localparam logic [1:0] SEL_NOTA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ALU1bit.sv
// Single-bit combinational ALU.
//   a, b : operand bits
//   sel  : 00 AND, 01 OR, 10 XOR, 11 NOT a
//   y    : result bit
module ALU1bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] sel,
   output logic       y
);

   always_comb begin
      case (sel)
         SEL_AND: y = a & b;
         SEL_OR:  y = a | b;
         SEL_XOR: y = a ^ b;
         default: y = ~a;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer in front of ALU1bit. Accepts WIDTH-bit operands, feeds
// one bit pair per cycle (LSB first) through the 1-bit ALU and returns the
// reassembled word over a valid/ready handshake.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_sel  : operands and op select
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   out_y               : result word, updated on entry to DONE
//   busy                : high in SHIFT or DONE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_SHIFT | one bit pair per cycle through ALU1bit, WIDTH cycles
// ST_DONE  | result presented, held until out_ready
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] y_q;
   logic [1:0]       sel_q;
   logic [CNT_W-1:0] cnt;
   logic             y_bit;
   logic             accept;
   logic             last_bit;

   ALU1bit u_alu (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .sel (sel_q),
      .y   (y_bit)
   );

   assign accept   = in_valid && in_ready;
   assign last_bit = (state == ST_SHIFT) && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)                 state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit)               state_nxt = ST_DONE;
         ST_DONE:  if (out_valid && out_ready) state_nxt = ST_IDLE;
         default:                              state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode from registered state only, so neither handshake has a
   // combinational path from its own input.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
      busy      = (state == ST_SHIFT) || (state == ST_DONE);
      out_y     = y_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sel_q  <= '0;
         cnt    <= '0;
         result <= '0;
         y_q    <= '0;
      end else if (accept) begin
         a_sh   <= in_a;
         b_sh   <= in_b;
         sel_q  <= in_sel;
         cnt    <= '0;
         result <= '0;
      end else if (state == ST_SHIFT) begin
         result <= {y_bit, result[WIDTH-1:1]};
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         // Counter parks at the last index instead of wrapping.
         if (!last_bit) cnt <= cnt + 1'b1;
         // Output word is loaded once, with the final bit folded in.
         if (last_bit)  y_q <= {y_bit, result[WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;

   logic clk;
   logic rst;

   logic        iv8,  ir8,  ov8,  or8,  bs8;
   logic [7:0]  ia8,  ib8,  oy8;
   logic [1:0]  is8;
   logic        iv2,  ir2,  ov2,  or2,  bs2;
   logic [1:0]  ia2,  ib2,  oy2;
   logic [1:0]  is2;
   logic        iv32, ir32, ov32, or32, bs32;
   logic [31:0] ia32, ib32, oy32;
   logic [1:0]  is32;

   int n_cmp = 0;
   int n_bad = 0;

   alu_serial_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(ia8), .in_b(ib8),
      .in_sel(is8), .out_valid(ov8), .out_ready(or8), .out_y(oy8), .busy(bs8));

   alu_serial_seq #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(ia2), .in_b(ib2),
      .in_sel(is2), .out_valid(ov2), .out_ready(or2), .out_y(oy2), .busy(bs2));

   alu_serial_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(ia32), .in_b(ib32),
      .in_sel(is32), .out_valid(ov32), .out_ready(or32), .out_y(oy32), .busy(bs32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(input int idx);
      case (idx)
         0:       return 8;
         1:       return 2;
         default: return 32;
      endcase
   endfunction

   // Reference: whole-word bitwise op, truncated to the instance width.
   function automatic logic [31:0] model(input int w, input logic [1:0] sel,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [31:0] mask;
      case (sel)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~a;
      endcase
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return r & mask;
   endfunction

   task automatic drive(input int idx, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] s);
      case (idx)
         0: begin iv8  = v; ia8  = a[7:0]; ib8  = b[7:0]; is8  = s; end
         1: begin iv2  = v; ia2  = a[1:0]; ib2  = b[1:0]; is2  = s; end
         default: begin iv32 = v; ia32 = a; ib32 = b; is32 = s; end
      endcase
   endtask

   task automatic set_ordy(input int idx, input logic r);
      case (idx)
         0:       or8  = r;
         1:       or2  = r;
         default: or32 = r;
      endcase
   endtask

   function automatic logic get_ir(input int idx);
      case (idx) 0: return ir8; 1: return ir2; default: return ir32; endcase
   endfunction
   function automatic logic get_ov(input int idx);
      case (idx) 0: return ov8; 1: return ov2; default: return ov32; endcase
   endfunction
   function automatic logic get_bs(input int idx);
      case (idx) 0: return bs8; 1: return bs2; default: return bs32; endcase
   endfunction
   function automatic logic [31:0] get_oy(input int idx);
      case (idx)
         0:       return {24'd0, oy8};
         1:       return {30'd0, oy2};
         default: return oy32;
      endcase
   endfunction

   // One full transaction: accept, garbage on in_valid during SHIFT (must be
   // ignored), hold backpressure for 'hold' cycles, then release.
   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel, input int hold);
      int          w;
      int          lat;
      logic [31:0] exp;
      logic        stable;
      w   = wid(idx);
      exp = model(w, sel, a, b);
      @(negedge clk);
      n_cmp++;
      if (get_ir(idx) !== 1'b1) begin
         n_bad++; $display("FAIL idle_in_ready w=%0d got=%b want=1", w, get_ir(idx));
      end
      drive(idx, 1'b1, a, b, sel);
      set_ordy(idx, 1'b0);
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      drive(idx, 1'b1, $urandom, $urandom, 2'($urandom));
      n_cmp++;
      if (get_bs(idx) !== 1'b1) begin
         n_bad++; $display("FAIL busy_after_accept w=%0d got=%b want=1", w, get_bs(idx));
      end
      while (get_ov(idx) !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      drive(idx, 1'b0, 32'd0, 32'd0, 2'd0);
      n_cmp++;
      if (lat != w + 1) begin
         n_bad++; $display("FAIL latency w=%0d got=%0d want=%0d", w, lat, w + 1);
      end
      n_cmp++;
      if (get_oy(idx) !== exp) begin
         n_bad++; $display("FAIL result w=%0d sel=%0d a=%h b=%h got=%h want=%h",
                           w, sel, a, b, get_oy(idx), exp);
      end
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (get_oy(idx) !== exp || get_ov(idx) !== 1'b1 || get_ir(idx) !== 1'b0)
            stable = 1'b0;
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_bad++; $display("FAIL hold_stable w=%0d hold=%0d got=0 want=1", w, hold);
      end
      set_ordy(idx, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_ordy(idx, 1'b0);
      n_cmp++;
      if (get_ov(idx) !== 1'b0 || get_ir(idx) !== 1'b1 || get_oy(idx) !== exp) begin
         n_bad++; $display("FAIL release w=%0d got ov=%b ir=%b y=%h want ov=0 ir=1 y=%h",
                           w, get_ov(idx), get_ir(idx), get_oy(idx), exp);
      end
   endtask

   task automatic test_reset;
      // Give every instance a nonzero output, then reset mid-SHIFT mid-cycle.
      run_op(0, 32'hF0, 32'h3C, 2'b00, 0);
      run_op(1, 32'h3, 32'h1, 2'b01, 0);
      run_op(2, 32'hDEAD_BEEF, 32'h0, 2'b01, 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'd0, 32'd0, 2'd0);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (get_ir(i) !== 1'b1 || get_ov(i) !== 1'b0 || get_bs(i) !== 1'b0 ||
             get_oy(i) !== 32'd0) begin
            n_bad++; $display("FAIL async_reset w=%0d got ir=%b ov=%b busy=%b y=%h want 1 0 0 0",
                              wid(i), get_ir(i), get_ov(i), get_bs(i), get_oy(i));
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      for (int i = 0; i < 3; i++) begin
         run_op(i, 32'hF0, 32'h3C, 2'b00, 1);
         run_op(i, 32'hA5, 32'h0F, 2'b01, 0);
         run_op(i, 32'hA5, 32'h0F, 2'b10, 2);
         run_op(i, 32'h81, 32'hFF, 2'b11, 0);
         run_op(i, 32'h81, 32'h00, 2'b11, 0);
      end
      run_op(2, 32'h8000_0001, 32'hFFFF_FFFF, 2'b10, 1);
   endtask

   task automatic test_backpressure;
      int          lat;
      logic        stable;
      logic [31:0] exp1;
      logic [31:0] exp2;
      exp1 = model(8, 2'b10, 32'h5A, 32'h33);
      exp2 = model(8, 2'b01, 32'hC3, 32'h0F);
      @(negedge clk);
      drive(0, 1'b1, 32'h5A, 32'h33, 2'b10);
      or8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
      lat = 1;
      while (ov8 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (oy8 !== exp1[7:0] || ir8 !== 1'b0 || ov8 !== 1'b1) stable = 1'b0;
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_bad++; $display("FAIL bp_stable got y=%h ir=%b want y=%h ir=0", oy8, ir8, exp1[7:0]);
      end
      or8 = 1'b1;
      drive(0, 1'b1, 32'hC3, 32'h0F, 2'b01);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ir8 !== 1'b1 || bs8 !== 1'b0 || ov8 !== 1'b0) begin
         n_bad++; $display("FAIL bp_no_early_accept got ir=%b busy=%b ov=%b want 1 0 0", ir8, bs8, ov8);
      end
      or8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
      n_cmp++;
      if (bs8 !== 1'b1) begin
         n_bad++; $display("FAIL bp_next_accept got busy=%b want 1", bs8);
      end
      lat = 1;
      while (ov8 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      n_cmp++;
      if (lat != 9 || oy8 !== exp2[7:0]) begin
         n_bad++; $display("FAIL bp_second got lat=%0d y=%h want lat=9 y=%h", lat, oy8, exp2[7:0]);
      end
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or8 = 1'b0;
   endtask

   task automatic test_abort;
      int          nvalid;
      logic [31:0] ycap;
      @(negedge clk);
      drive(0, 1'b1, 32'h3C, 32'h96, 2'b10);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bs8 !== 1'b0 || ov8 !== 1'b0 || oy8 !== 8'h00) begin
         n_bad++; $display("FAIL abort_reset got busy=%b ov=%b y=%h want 0 0 00", bs8, ov8, oy8);
      end
      @(negedge clk);
      rst = 1'b0;
      or8 = 1'b1;
      drive(0, 1'b1, 32'hFF, 32'hFF, 2'b00);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
      nvalid = 0;
      ycap = 32'd0;
      for (int i = 0; i < 40; i++) begin
         if (ov8 === 1'b1) begin nvalid++; ycap = {24'd0, oy8}; end
         @(negedge clk);
      end
      or8 = 1'b0;
      n_cmp++;
      if (nvalid != 1 || ycap !== 32'hFF) begin
         n_bad++; $display("FAIL abort_single got n=%0d y=%h want n=1 y=ff", nvalid, ycap);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 15; k++) begin
            run_op(i, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
         end
      end
   endtask

   task automatic test_back_to_back;
      int edges;
      int accepts;
      int first;
      int second;
      @(negedge clk);
      or2 = 1'b1;
      drive(1, 1'b1, 32'h2, 32'h3, 2'b10);
      accepts = 0;
      first = 0;
      second = 0;
      edges = 0;
      while (accepts < 2 && edges < 50) begin
         if (ir2 === 1'b1) begin
            accepts++;
            if (accepts == 1) first = edges; else second = edges;
         end
         @(negedge clk);
         edges++;
      end
      drive(1, 1'b0, 32'd0, 32'd0, 2'd0);
      repeat (6) @(negedge clk);
      or2 = 1'b0;
      n_cmp++;
      if (second - first != 4) begin
         n_bad++; $display("FAIL throughput w=2 got=%0d want=4", second - first);
      end
   endtask

   initial begin
      rst = 1'b1;
      or8 = 1'b0; or2 = 1'b0; or32 = 1'b0;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'd0, 32'd0, 2'd0);
      #12 rst = 1'b0;
      test_reset;
      test_directed;
      test_backpressure;
      test_abort;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
